// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one memory read per instruction, holds the fetched word
// until decode accepts it, and supports redirect (flush) at any point of a fetch.
module instruction_fetch #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  pc_in,
    output logic                   inc_PC,
    output logic [DATA_WIDTH-1:0]  mem_addr,
    output logic                   mem_rd,
    input  logic                   mem_ready,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    output logic [DATA_WIDTH-1:0]  ir_out,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  ir_q, ir_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   rd_q, rd_d;
    logic                   inc_q, inc_d;
    logic                   vld_q, vld_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        inc_d   = 1'b0;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (enable && !flush) begin
                    state_d = REQ;
                    addr_d  = pc_in;
                    rd_d    = 1'b1;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    rd_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        ir_d    = mem_data;
                        vld_d   = 1'b1;
                        inc_d   = 1'b1;
                    end
                end else if (flush) begin
                    // read is already in flight; wait out its response before re-arming
                    state_d = DRAIN;
                    rd_d    = 1'b0;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end else if (ir_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    cnt_d   = cnt_q + COUNT_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (mem_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            inc_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            inc_q   <= inc_d;
            vld_q   <= vld_d;
        end
    end

    assign inc_PC      = inc_q;
    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign ir_out      = ir_q;
    assign ir_valid    = vld_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus queues expected addresses/instructions,
// a negedge monitor pops and compares them when the DUT presents a request or handshake.
module tb_instruction_fetch;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          clear_n, enable, flush, mem_ready, ir_ready;
    logic [DW-1:0] pc_in, mem_data, mem_addr, ir_out;
    logic          inc_PC, mem_rd, ir_valid;
    logic [CW-1:0] fetch_count;

    instruction_fetch #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .clear_n(clear_n), .enable(enable), .flush(flush),
        .pc_in(pc_in), .inc_PC(inc_PC), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ready(mem_ready), .mem_data(mem_data), .ir_out(ir_out),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    int rd_cycles = 0, inc_cycles = 0;
    logic [DW-1:0] addr_q[$];
    logic [DW-1:0] instr_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: new read request -> compare address; accepted instruction -> compare data.
    logic rd_prev = 1'b0;
    always @(negedge clock) begin
        if (mem_rd) rd_cycles++;
        if (inc_PC) inc_cycles++;
        if (mem_rd && !rd_prev) begin
            if (addr_q.size() == 0) check("unexpected_read", 32'(mem_rd), 32'd0);
            else check("mem_addr", mem_addr, addr_q.pop_front());
        end
        if (ir_valid && ir_ready && !flush) begin
            if (instr_q.size() == 0) check("unexpected_accept", 32'(ir_valid), 32'd0);
            else check("ir_out", ir_out, instr_q.pop_front());
        end
        rd_prev = mem_rd;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [DW-1:0] pc, input logic [DW-1:0] data);
        enable = 1'b1; pc_in = pc; ir_ready = 1'b1;
        addr_q.push_back(pc);
        instr_q.push_back(data);
        step();                               // IDLE -> REQ
        enable = 1'b0; mem_ready = 1'b1; mem_data = data;
        step();                               // REQ -> HOLD
        mem_ready = 1'b0;
        step();                               // HOLD -> IDLE
    endtask

    int rd0, inc0;

    initial begin
        clear_n = 1'b0; enable = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        ir_ready = 1'b0; pc_in = '0; mem_data = '0;
        #1;
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_inc_PC", 32'(inc_PC), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ir_out", ir_out, 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        step(); step();
        clear_n = 1'b1;
        step();

        // basic zero-wait fetch
        rd0 = rd_cycles; inc0 = inc_cycles;
        fetch(32'h10, 32'hA5A5_0001);
        check("basic_count", 32'(fetch_count), 32'd1);
        check("basic_rd_cycles", 32'(rd_cycles - rd0), 32'd1);
        check("basic_inc_pulses", 32'(inc_cycles - inc0), 32'd1);
        check("basic_ir_retained", ir_out, 32'hA5A5_0001);

        // three wait states
        rd0 = rd_cycles; inc0 = inc_cycles;
        enable = 1'b1; pc_in = 32'h20; ir_ready = 1'b1;
        addr_q.push_back(32'h20); instr_q.push_back(32'h1111_2222);
        step();
        enable = 1'b0; pc_in = 32'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_addr_stable", mem_addr, 32'h20);
            check("wait_rd_held", 32'(mem_rd), 32'd1);
        end
        mem_ready = 1'b1; mem_data = 32'h1111_2222;
        step();
        mem_ready = 1'b0;
        step();
        check("wait_rd_cycles", 32'(rd_cycles - rd0), 32'd4);
        check("wait_inc_pulses", 32'(inc_cycles - inc0), 32'd1);
        check("wait_count", 32'(fetch_count), 32'd2);

        // back-pressure: decode stalls for 5 cycles, enable stays high
        rd0 = rd_cycles; inc0 = inc_cycles;
        enable = 1'b1; pc_in = 32'h30; ir_ready = 1'b0;
        addr_q.push_back(32'h30); instr_q.push_back(32'h3333_4444);
        step();
        mem_ready = 1'b1; mem_data = 32'h3333_4444;
        step();
        mem_ready = 1'b0; mem_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("bp_ir_valid", 32'(ir_valid), 32'd1);
            check("bp_ir_out", ir_out, 32'h3333_4444);
            check("bp_count", 32'(fetch_count), 32'd2);
            step();
        end
        check("bp_rd_cycles", 32'(rd_cycles - rd0), 32'd1);
        check("bp_inc_pulses", 32'(inc_cycles - inc0), 32'd1);
        ir_ready = 1'b1; enable = 1'b0;
        step();
        check("bp_count_after", 32'(fetch_count), 32'd3);

        // flush in REQ, response arrives two cycles later and is dropped
        inc0 = inc_cycles;
        enable = 1'b1; pc_in = 32'h40;
        addr_q.push_back(32'h40);
        step();
        enable = 1'b0; flush = 1'b1;
        step();                               // REQ -> DRAIN
        flush = 1'b0;
        check("drain_mem_rd", 32'(mem_rd), 32'd0);
        step();
        mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
        step();                               // DRAIN -> IDLE
        mem_ready = 1'b0;
        check("flushreq_ir_valid", 32'(ir_valid), 32'd0);
        check("flushreq_ir_out", ir_out, 32'h3333_4444);
        check("flushreq_inc", 32'(inc_cycles - inc0), 32'd0);
        fetch(32'h50, 32'h5555_6666);
        check("flushreq_count", 32'(fetch_count), 32'd4);

        // flush in HOLD beats ir_ready
        inc0 = inc_cycles;
        enable = 1'b1; pc_in = 32'h60; ir_ready = 1'b0;
        addr_q.push_back(32'h60);
        step();
        enable = 1'b0; mem_ready = 1'b1; mem_data = 32'h6060_6060;
        step();
        mem_ready = 1'b0; flush = 1'b1; ir_ready = 1'b1;
        step();
        flush = 1'b0;
        check("flushhold_ir_valid", 32'(ir_valid), 32'd0);
        check("flushhold_count", 32'(fetch_count), 32'd4);
        check("flushhold_inc", 32'(inc_cycles - inc0), 32'd1);

        // asynchronous reset between edges while in REQ
        enable = 1'b1; pc_in = 32'h70;
        addr_q.push_back(32'h70);
        step();
        enable = 1'b0;
        @(negedge clock); #1;
        check("pre_rst_mem_rd", 32'(mem_rd), 32'd1);
        clear_n = 1'b0;
        #1;
        check("arst_mem_rd", 32'(mem_rd), 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_count", 32'(fetch_count), 32'd0);
        clear_n = 1'b1;
        step();
        fetch(32'h80, 32'h8888_0000);
        check("post_rst_count", 32'(fetch_count), 32'd1);

        // counter wrap: 15 more accepts on a 4-bit counter
        for (int i = 0; i < 14; i++) fetch(32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        check("pre_wrap_count", 32'(fetch_count), 32'd15);
        fetch(32'h200, 32'hC0DE_0001);
        check("wrap_count", 32'(fetch_count), 32'd0);

        step();
        check("addr_queue_empty", 32'(addr_q.size()), 32'd0);
        check("instr_queue_empty", 32'(instr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of pc_in, mem_addr, mem_data and ir_out.
REQ-002 Parameter COUNT_WIDTH, default 16, SHALL set the width of fetch_count.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 clear_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  fetch permitted; 0 holds the block in IDLE.
REQ-007 flush  input  1  redirect: abort the current fetch and discard any held instruction.
REQ-008 pc_in  input  DATA_WIDTH  current program counter value.
REQ-009 inc_PC  output  1  one-cycle request to the program counter to advance.
REQ-010 mem_addr  output  DATA_WIDTH  instruction memory read address.
REQ-011 mem_rd  output  1  memory read request; level, held until mem_ready.
REQ-012 mem_ready  input  1  memory read data valid this cycle.
REQ-013 mem_data  input  DATA_WIDTH  memory read data.
REQ-014 ir_out  output  DATA_WIDTH  fetched instruction.
REQ-015 ir_valid  output  1  ir_out holds an instruction not yet accepted.
REQ-016 ir_ready  input  1  decode accepts ir_out when ir_valid and ir_ready are both high.
REQ-017 fetch_count  output  COUNT_WIDTH  number of instructions accepted by decode; wraps.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, HOLD, DRAIN; all outputs SHALL be registered.
REQ-019 IDLE: if enable=1 and flush=0, the block SHALL latch mem_addr<=pc_in and go to REQ; otherwise it SHALL stay in IDLE.
REQ-020 REQ: mem_rd SHALL be 1 and mem_addr SHALL remain stable for the whole state.
REQ-021 REQ with flush=1 and mem_ready=0: the block SHALL go to DRAIN with no ir capture and no inc_PC.
REQ-022 REQ with flush=1 and mem_ready=1: the block SHALL discard mem_data and go to IDLE with no inc_PC.
REQ-023 REQ with flush=0 and mem_ready=1: the block SHALL capture ir_out<=mem_data, set ir_valid=1 and inc_PC=1, and go to HOLD.
REQ-024 inc_PC SHALL be high for exactly one cycle, the first HOLD cycle, independent of flush and ir_ready.
REQ-025 DRAIN: mem_rd SHALL be 0; on mem_ready=1 the data SHALL be dropped and the block SHALL go to IDLE; flush SHALL be ignored in DRAIN.
REQ-026 HOLD: flush=1 SHALL clear ir_valid and go to IDLE without incrementing fetch_count; flush has priority over ir_ready.
REQ-027 HOLD: ir_ready=1 with flush=0 SHALL clear ir_valid, increment fetch_count modulo 2^COUNT_WIDTH, and go to IDLE.
REQ-028 ir_out SHALL hold its value while ir_valid=1 and SHALL retain its last value after ir_valid falls.
REQ-029 enable=0 SHALL only block IDLE->REQ; an outstanding REQ or HOLD SHALL complete normally.
REQ-030 Minimum fetch period with zero-wait memory and ir_ready=1 SHALL be 3 cycles: IDLE, REQ, HOLD.
REQ-031 At most one memory read SHALL be outstanding; mem_rd SHALL never assert in HOLD or DRAIN.
REQ-032 mem_ready outside REQ/DRAIN SHALL be ignored.

Reset
REQ-033 clear_n=0 SHALL immediately force state=IDLE, mem_rd=0, inc_PC=0, ir_valid=0, mem_addr=0, ir_out=0 and fetch_count=0, independent of clock.
REQ-034 Reset mid-fetch SHALL abandon the read; the first fetch after release SHALL restart from IDLE.

Verification
REQ-035 Basic: reset, enable=1, pc_in=0x10, mem_ready=1 in the first REQ cycle with mem_data=0xA5A5_0001, ir_ready=1 -> mem_addr=0x10, mem_rd for 1 cycle, ir_out=0xA5A5_0001, inc_PC for 1 cycle, fetch_count=1.
REQ-036 Wait states: mem_ready delayed 3 cycles -> mem_rd high for 4 cycles, mem_addr stable, a single inc_PC pulse.
REQ-037 Back-pressure: ir_ready=0 for 5 cycles in HOLD -> ir_valid and ir_out stable, inc_PC pulses only once, no new mem_rd, fetch_count unchanged until acceptance.
REQ-038 Flush in REQ: flush=1 while mem_ready=0, mem_ready arrives 2 cycles later with data 0xDEAD_BEEF -> DRAIN, data dropped, ir_valid stays 0, no inc_PC, next fetch uses the new pc_in.
REQ-039 Flush in HOLD with ir_ready=1 in the same cycle -> ir_valid=0, fetch_count unchanged, IDLE.
REQ-040 Async reset asserted mid-REQ between clock edges -> mem_rd=0 and state=IDLE before the next edge; fetch_count wraps from 0xFFFF to 0 after 65536 accepts.
